cache_2way: RTL and testbench

- Parametrised successor to the direct-mapped CPU cache: 2-way set-associative, write-through, no-write-allocate, with a multi-word block refill and per-set LRU replacement.
- Sits between one CPU port and the memory controller. Accepts the same packed request format, generalised in width.
- Accepts a strobed invalidate from the controller for coherence.

---
 rtl/cache_2way.sv | 212 +++++++++++++++++++++
 tb/tb_cache_2way.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_2way.sv
// cache_2way: 2-way set-associative, write-through, no-write-allocate CPU cache
// with multi-word block refill, per-set LRU replacement and coherence invalidate.
//
// Ports:
//   clock, reset (async, active-low)
//   cpu_request {rw, data, address}, cpu_request_ready   - CPU request in
//   invalidate_address, invalidate_valid                 - coherence invalidate
//   memory_response, memory_response_ready               - refill block / write ack
//   memory_request {rw, data, address}, memory_request_ready - memory request out
//   data_out, data_out_ready                             - CPU completion
//   busy                                                 - FSM not idle
//   hit_count, miss_count (only with `define CACHE_STATS_EN)
module cache_2way #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int WORDS_PER_BLOCK = 2,
    parameter int SETS            = 128,
    parameter int STAT_WIDTH      = 16
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [DATA_WIDTH+ADDR_WIDTH:0]        cpu_request,
    input  logic                                  cpu_request_ready,
    input  logic [ADDR_WIDTH-1:0]                 invalidate_address,
    input  logic                                  invalidate_valid,
    input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] memory_response,
    input  logic                                  memory_response_ready,
    output logic [DATA_WIDTH+ADDR_WIDTH:0]        memory_request,
    output logic                                  memory_request_ready,
    output logic [DATA_WIDTH-1:0]                 data_out,
    output logic                                  data_out_ready,
`ifdef CACHE_STATS_EN
    output logic [STAT_WIDTH-1:0]                 hit_count,
    output logic [STAT_WIDTH-1:0]                 miss_count,
`endif
    output logic                                  busy
);

    localparam int OFF   = $clog2(WORDS_PER_BLOCK);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = ADDR_WIDTH - IDX - OFF;
    localparam int BLK   = DATA_WIDTH * WORDS_PER_BLOCK;
    localparam int REQ_W = 1 + DATA_WIDTH + ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        COMPARE_TAG    = 2'd1,
        WAIT_ON_MEMORY = 2'd2
    } state_t;

    state_t               state_q;
    logic [REQ_W-1:0]     req_q;
    logic [1:0][SETS-1:0] valid_q;
    logic [SETS-1:0]      lru_q;
    logic                 victim_q;
    logic [TAG-1:0]       tag_q  [2][SETS];
    logic [BLK-1:0]       data_q [2][SETS];

    logic                  req_rw;
    logic [TAG-1:0]        req_tag;
    logic [IDX-1:0]        req_idx;
    logic [OFF-1:0]        req_off;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  hit0;
    logic                  hit1;
    logic                  hit;
    logic                  hit_way;
    logic [BLK-1:0]        hit_blk;
    logic [DATA_WIDTH-1:0] hit_word;
    logic [DATA_WIDTH-1:0] resp_word;
    logic                  victim_way;
    logic                  refill;
    logic                  write_hit;
    logic [IDX-1:0]        inv_idx;
    logic [TAG-1:0]        inv_tag;
    logic [1:0]            inv_kill;

    assign req_rw    = req_q[REQ_W-1];
    assign req_wdata = req_q[ADDR_WIDTH +: DATA_WIDTH];
    assign req_tag   = req_q[ADDR_WIDTH-1 -: TAG];
    assign req_idx   = req_q[OFF +: IDX];
    assign req_off   = req_q[OFF-1:0];

    assign inv_tag = invalidate_address[ADDR_WIDTH-1 -: TAG];
    assign inv_idx = invalidate_address[OFF +: IDX];

    assign hit0    = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1    = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;
    assign hit_blk = hit0 ? data_q[0][req_idx] : data_q[1][req_idx];
    assign hit_word  = hit_blk[req_off*DATA_WIDTH +: DATA_WIDTH];
    assign resp_word = memory_response[req_off*DATA_WIDTH +: DATA_WIDTH];

    // Fill invalid ways first, then fall back to the LRU pointer.
    assign victim_way = !valid_q[0][req_idx] ? 1'b0 :
                        !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

    assign refill    = (state_q == WAIT_ON_MEMORY) && memory_response_ready && !req_rw;
    assign write_hit = (state_q == COMPARE_TAG) && req_rw && hit;

    // The way being refilled this cycle is matched against its new tag,
    // so a same-cycle invalidate of the incoming line leaves it invalid.
    always_comb begin
        inv_kill = '0;
        for (int w = 0; w < 2; w++) begin
            if (refill && (victim_q == w[0]) && (req_idx == inv_idx)) begin
                inv_kill[w] = invalidate_valid && (req_tag == inv_tag);
            end else begin
                inv_kill[w] = invalidate_valid && (tag_q[w][inv_idx] == inv_tag);
            end
        end
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q              <= IDLE;
            req_q                <= '0;
            valid_q              <= '0;
            lru_q                <= '0;
            victim_q             <= 1'b0;
            memory_request       <= '0;
            memory_request_ready <= 1'b0;
            data_out             <= '0;
            data_out_ready       <= 1'b0;
        end else begin
            data_out_ready <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_request_ready) begin
                        req_q   <= cpu_request;
                        state_q <= COMPARE_TAG;
                    end
                end
                COMPARE_TAG: begin
                    if (!req_rw && hit) begin
                        data_out       <= hit_word;
                        data_out_ready <= 1'b1;
                        lru_q[req_idx] <= ~hit_way;
                        state_q        <= IDLE;
                    end else if (!req_rw) begin
                        memory_request <= {1'b0, {DATA_WIDTH{1'b0}},
                                           req_tag, req_idx, {OFF{1'b0}}};
                        memory_request_ready <= 1'b1;
                        victim_q             <= victim_way;
                        state_q              <= WAIT_ON_MEMORY;
                    end else begin
                        memory_request       <= req_q;
                        memory_request_ready <= 1'b1;
                        if (hit) begin
                            lru_q[req_idx] <= ~hit_way;
                        end
                        state_q <= WAIT_ON_MEMORY;
                    end
                end
                WAIT_ON_MEMORY: begin
                    if (memory_response_ready) begin
                        if (!req_rw) begin
                            valid_q[victim_q][req_idx] <= 1'b1;
                            lru_q[req_idx]             <= ~victim_q;
                            data_out                   <= resp_word;
                        end
                        data_out_ready       <= 1'b1;
                        memory_request       <= '0;
                        memory_request_ready <= 1'b0;
                        state_q              <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Placed last so an invalidate overrides a same-cycle fill.
            for (int w = 0; w < 2; w++) begin
                if (inv_kill[w]) begin
                    valid_q[w][inv_idx] <= 1'b0;
                end
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clock) begin
        if (write_hit) begin
            data_q[hit_way][req_idx][req_off*DATA_WIDTH +: DATA_WIDTH] <= req_wdata;
        end
        if (refill) begin
            data_q[victim_q][req_idx] <= memory_response;
            tag_q[victim_q][req_idx]  <= req_tag;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state_q == COMPARE_TAG) && !req_rw) begin
            if (hit) begin
                if (hit_count != {STAT_WIDTH{1'b1}}) begin
                    hit_count <= hit_count + 1'b1;
                end
            end else begin
                if (miss_count != {STAT_WIDTH{1'b1}}) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_2way.sv
// tb_cache_2way: directed self-checking bench for cache_2way
// (default geometry: 16-bit address, 8-bit data, 2 words/block, 128 sets).
module tb_cache_2way;

    logic        clock;
    logic        reset;
    logic [24:0] cpu_request;
    logic        cpu_request_ready;
    logic [15:0] invalidate_address;
    logic        invalidate_valid;
    logic [15:0] memory_response;
    logic        memory_response_ready;
    logic [24:0] memory_request;
    logic        memory_request_ready;
    logic [7:0]  data_out;
    logic        data_out_ready;
    logic        busy;
`ifdef CACHE_STATS_EN
    logic [1:0]  hit_count;
    logic [1:0]  miss_count;
`endif

    int checks = 0;
    int errors = 0;

    cache_2way #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(8),
        .WORDS_PER_BLOCK(2),
        .SETS(128),
        .STAT_WIDTH(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cpu_request(cpu_request),
        .cpu_request_ready(cpu_request_ready),
        .invalidate_address(invalidate_address),
        .invalidate_valid(invalidate_valid),
        .memory_response(memory_response),
        .memory_response_ready(memory_response_ready),
        .memory_request(memory_request),
        .memory_request_ready(memory_request_ready),
        .data_out(data_out),
        .data_out_ready(data_out_ready),
`ifdef CACHE_STATS_EN
        .hit_count(hit_count),
        .miss_count(miss_count),
`endif
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Drives one CPU transaction and plays memory: answers the memory
    // request after 'hold' cycles, optionally with a same-cycle invalidate.
    task automatic run_txn(
        input  logic        rw,
        input  logic [7:0]  wd,
        input  logic [15:0] addr,
        input  logic [15:0] resp,
        input  int          hold,
        input  logic        inv,
        output logic        pulse,
        output logic [7:0]  dout,
        output logic        mseen,
        output logic [24:0] mreq,
        output logic        mstable,
        output int          lat,
        output logic        mclear
    );
        int h;
        h = 0;
        pulse = 1'b0; dout = '0; mseen = 1'b0; mreq = '0;
        mstable = 1'b1; lat = 0; mclear = 1'b0;
        cpu_request = {rw, wd, addr};
        cpu_request_ready = 1'b1;
        for (int c = 1; c <= 40 && !pulse; c++) begin
            @(posedge clock);
            #1;
            memory_response_ready = 1'b0;
            invalidate_valid = 1'b0;
            if (data_out_ready) begin
                pulse = 1'b1;
                dout = data_out;
                lat = c;
                mclear = !memory_request_ready && (memory_request == '0);
            end else if (memory_request_ready) begin
                if (!mseen) begin
                    mseen = 1'b1;
                    mreq = memory_request;
                end else if (memory_request !== mreq) begin
                    mstable = 1'b0;
                end
                if (h == hold) begin
                    memory_response = resp;
                    memory_response_ready = 1'b1;
                    if (inv) begin
                        invalidate_address = addr;
                        invalidate_valid = 1'b1;
                    end
                end
                h++;
            end
        end
        cpu_request_ready = 1'b0;
    endtask

    task automatic strobe_inval(input logic [15:0] addr);
        invalidate_address = addr;
        invalidate_valid = 1'b1;
        @(posedge clock);
        #1;
        invalidate_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic p, ms, st, mc;
        logic [7:0] d;
        logic [24:0] mq;
        int l;
        checks++;
        if (data_out !== 8'h00) begin
            errors++; $display("FAIL rst_data_out: got %h want 00", data_out);
        end
        checks++;
        if (data_out_ready !== 1'b0 || memory_request_ready !== 1'b0) begin
            errors++; $display("FAIL rst_strobes: got %b%b want 00", data_out_ready, memory_request_ready);
        end
        checks++;
        if (memory_request !== 25'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mreq_busy: got %h/%b want 0/0", memory_request, busy);
        end
`ifdef CACHE_STATS_EN
        checks++;
        if (hit_count !== 2'd0 || miss_count !== 2'd0) begin
            errors++; $display("FAIL rst_stats: got %0d/%0d want 0/0", hit_count, miss_count);
        end
`endif
        @(posedge clock);
        #1;
        reset = 1'b1;
        run_txn(1'b0, 8'h00, 16'h0102, 16'hAA55, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (p !== 1'b1 || d !== 8'h55) begin
            errors++; $display("FAIL first_miss: got pulse=%b data=%h want 1/55", p, d);
        end
        // Start a miss and abort it with reset while waiting on memory.
        cpu_request = {1'b0, 8'h00, 16'h0304};
        cpu_request_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (memory_request_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL wait_state: got mrr=%b busy=%b want 1/1", memory_request_ready, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (memory_request_ready !== 1'b0 || memory_request !== 25'h0) begin
            errors++; $display("FAIL async_rst_mreq: got %b/%h want 0/0", memory_request_ready, memory_request);
        end
        checks++;
        if (data_out !== 8'h00 || data_out_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL async_rst_out: got %h/%b/%b want 00/0/0", data_out, data_out_ready, busy);
        end
        cpu_request_ready = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (data_out_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_pulse: got %b/%b want 0/0", data_out_ready, busy);
        end
        reset = 1'b1;
        run_txn(1'b0, 8'h00, 16'h1235, 16'hBEEF, 1, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b1 || mq !== 25'h001234) begin
            errors++; $display("FAIL miss_req_1235: got seen=%b req=%h want 1/001234", ms, mq);
        end
        checks++;
        if (p !== 1'b1 || d !== 8'hBE || mc !== 1'b1) begin
            errors++; $display("FAIL miss_data_1235: got %b/%h/%b want 1/be/1", p, d, mc);
        end
        run_txn(1'b0, 8'h00, 16'h0102, 16'hAA55, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b1 || mq !== 25'h000102) begin
            errors++; $display("FAIL valid_cleared: got seen=%b req=%h want 1/000102", ms, mq);
        end
    endtask

    task automatic test_read_hit;
        logic p, ms, st, mc;
        logic [7:0] d;
        logic [24:0] mq;
        int l;
        run_txn(1'b0, 8'h00, 16'h1234, 16'h0000, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (p !== 1'b1 || d !== 8'hEF || ms !== 1'b0) begin
            errors++; $display("FAIL hit_1234: got %b/%h mreq=%b want 1/ef/0", p, d, ms);
        end
        checks++;
        if (l !== 2) begin
            errors++; $display("FAIL hit_latency: got %0d want 2", l);
        end
        // Issued immediately after the previous pulse: back-to-back.
        run_txn(1'b0, 8'h00, 16'h1235, 16'h0000, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (p !== 1'b1 || d !== 8'hBE || ms !== 1'b0 || l !== 2) begin
            errors++; $display("FAIL hit_1235: got %b/%h/%b/%0d want 1/be/0/2", p, d, ms, l);
        end
    endtask

    task automatic test_lru;
        logic p, ms, st, mc;
        logic [7:0] d;
        logic [24:0] mq;
        int l;
        run_txn(1'b0, 8'h00, 16'h3434, 16'h3322, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b1 || d !== 8'h22) begin
            errors++; $display("FAIL fill_3434: got %b/%h want 1/22", ms, d);
        end
        run_txn(1'b0, 8'h00, 16'h1234, 16'h0000, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b0 || d !== 8'hEF) begin
            errors++; $display("FAIL reuse_1234: got %b/%h want 0/ef", ms, d);
        end
        run_txn(1'b0, 8'h00, 16'h5634, 16'h6655, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b1 || mq !== 25'h005634 || d !== 8'h55) begin
            errors++; $display("FAIL fill_5634: got %b/%h/%h want 1/005634/55", ms, mq, d);
        end
        run_txn(1'b0, 8'h00, 16'h1234, 16'h0000, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b0 || d !== 8'hEF) begin
            errors++; $display("FAIL keep_1234: got %b/%h want 0/ef", ms, d);
        end
        run_txn(1'b0, 8'h00, 16'h3434, 16'h3322, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b1 || mq !== 25'h003434) begin
            errors++; $display("FAIL evicted_3434: got %b/%h want 1/003434", ms, mq);
        end
    endtask

    task automatic test_write;
        logic p, ms, st, mc;
        logic [7:0] d;
        logic [24:0] mq;
        int l;
        run_txn(1'b1, 8'h77, 16'h1234, 16'h0000, 3, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b1 || mq !== 25'h1771234 || st !== 1'b1) begin
            errors++; $display("FAIL wr_req: got %b/%h/%b want 1/1771234/1", ms, mq, st);
        end
        checks++;
        if (p !== 1'b1 || d !== 8'h22 || mc !== 1'b1) begin
            errors++; $display("FAIL wr_done: got %b/%h/%b want 1/22/1", p, d, mc);
        end
        run_txn(1'b0, 8'h00, 16'h1234, 16'h0000, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b0 || d !== 8'h77) begin
            errors++; $display("FAIL wr_hit_read: got %b/%h want 0/77", ms, d);
        end
        run_txn(1'b0, 8'h00, 16'h1235, 16'h0000, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b0 || d !== 8'hBE) begin
            errors++; $display("FAIL wr_other_word: got %b/%h want 0/be", ms, d);
        end
        run_txn(1'b1, 8'h99, 16'h4000, 16'h0000, 1, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (mq !== 25'h1994000 || p !== 1'b1) begin
            errors++; $display("FAIL wr_miss_req: got %h/%b want 1994000/1", mq, p);
        end
        run_txn(1'b0, 8'h00, 16'h4000, 16'h1199, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b1 || mq !== 25'h004000 || d !== 8'h99) begin
            errors++; $display("FAIL no_allocate: got %b/%h/%h want 1/004000/99", ms, mq, d);
        end
    endtask

    task automatic test_inval;
        logic p, ms, st, mc;
        logic [7:0] d;
        logic [24:0] mq;
        int l;
        strobe_inval(16'h1234);
        run_txn(1'b0, 8'h00, 16'h1234, 16'hCAFE, 1, 1'b1, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b1 || p !== 1'b1 || d !== 8'hFE) begin
            errors++; $display("FAIL inval_refill: got %b/%b/%h want 1/1/fe", ms, p, d);
        end
        run_txn(1'b0, 8'h00, 16'h1234, 16'hCAFE, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b1 || d !== 8'hFE) begin
            errors++; $display("FAIL inval_wins: got %b/%h want 1/fe", ms, d);
        end
        run_txn(1'b0, 8'h00, 16'h1235, 16'h0000, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b0 || d !== 8'hCA) begin
            errors++; $display("FAIL refetch_hit: got %b/%h want 0/ca", ms, d);
        end
        strobe_inval(16'h3434);
        strobe_inval(16'h3434);
        run_txn(1'b0, 8'h00, 16'h1234, 16'h0000, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b0 || d !== 8'hFE) begin
            errors++; $display("FAIL other_way_kept: got %b/%h want 0/fe", ms, d);
        end
        run_txn(1'b0, 8'h00, 16'h3435, 16'h3322, 0, 1'b0, p, d, ms, mq, st, l, mc);
        checks++;
        if (ms !== 1'b1 || mq !== 25'h003434 || d !== 8'h33) begin
            errors++; $display("FAIL inval_3434: got %b/%h/%h want 1/003434/33", ms, mq, d);
        end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats;
        checks++;
        if (hit_count !== 2'd3 || miss_count !== 2'd3) begin
            errors++; $display("FAIL stats_sat: got %0d/%0d want 3/3", hit_count, miss_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        cpu_request = '0;
        cpu_request_ready = 1'b0;
        invalidate_address = '0;
        invalidate_valid = 1'b0;
        memory_response = '0;
        memory_response_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        test_read_hit();
        test_lru();
        test_write();
        test_inval();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
